// File: rtl/axis_sink_bfm.sv
// AXI4-Stream slave sink: programmable TREADY back-pressure, FWFT capture FIFO,
// beat/packet/byte counters and a sticky stream-stability checker.
module axis_sink_bfm #(
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned DEPTH      = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    clr,
  input  logic [1:0]              mode,
  input  logic [7:0]              rnd_thr,
  input  logic [7:0]              per_len,
  input  logic [7:0]              per_on,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [8*DATA_BYTES-1:0] rd_data,
  output logic [DATA_BYTES-1:0]   rd_keep,
  output logic                    rd_last,
  output logic [31:0]             beat_cnt,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             byte_cnt,
  output logic                    err_stable
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [DATA_BYTES-1:0] keep;
    logic                  last;
  } beat_t;

  beat_t          mem [DEPTH];
  beat_t          cur, prev, head;
  logic [PW-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic           full, empty, full_n;
  logic [15:0]    lfsr, lfsr_n;
  logic [7:0]     pc, pc_n, len;
  logic           push, pop, rdy_n;
  logic           prev_valid, prev_ready, stall_break;
  logic [31:0]    keep_ones;

  assign cur  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign push = s_axis_tvalid & s_axis_tready & ~clr;
  assign pop  = ~empty & rd_ready & ~clr;

  assign wr_ptr_n = wr_ptr + PW'(push);
  assign rd_ptr_n = rd_ptr + PW'(pop);
  assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign len    = (per_len == 8'd0) ? 8'd1 : per_len;
  assign pc_n   = (({1'b0, pc} + 9'd1) >= {1'b0, len}) ? 8'd0 : pc + 8'd1;

  // A stalled beat must be held: valid kept high and payload unchanged
  assign stall_break = prev_valid & ~prev_ready & (~s_axis_tvalid | (cur != prev));

  always_comb begin
    keep_ones = 32'd0;
    for (int i = 0; i < DATA_BYTES; i++) keep_ones = keep_ones + 32'(s_axis_tkeep[i]);
  end

  // TREADY is registered: evaluated from the next-cycle values of lfsr, pc, full and clr
  always_comb begin
    rdy_n = 1'b0;
    case (mode)
      2'd0:    rdy_n = 1'b1;
      2'd1:    rdy_n = 1'b0;
      2'd2:    rdy_n = (lfsr_n[7:0] < rnd_thr);
      default: rdy_n = (pc_n < per_on);
    endcase
    rdy_n = rdy_n & ~full_n & ~clr;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axis_tready <= 1'b0;
      lfsr          <= LFSR_SEED;
      pc            <= 8'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      beat_cnt      <= 32'd0;
      pkt_cnt       <= 32'd0;
      byte_cnt      <= 32'd0;
      err_stable    <= 1'b0;
      prev_valid    <= 1'b0;
      prev_ready    <= 1'b0;
      prev          <= '0;
    end else begin
      s_axis_tready <= rdy_n;
      lfsr          <= lfsr_n;
      pc            <= pc_n;
      prev_valid    <= s_axis_tvalid;
      prev_ready    <= s_axis_tready;
      prev          <= cur;
      if (clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        full       <= 1'b0;
        empty      <= 1'b1;
        beat_cnt   <= 32'd0;
        pkt_cnt    <= 32'd0;
        byte_cnt   <= 32'd0;
        err_stable <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr_n;
        rd_ptr <= rd_ptr_n;
        full   <= full_n;
        empty  <= (wr_ptr_n == rd_ptr_n);
        if (push) begin
          beat_cnt <= beat_cnt + 32'd1;
          pkt_cnt  <= pkt_cnt + 32'(s_axis_tlast);
          byte_cnt <= byte_cnt + keep_ones;
        end
        if (stall_break) err_stable <= 1'b1;
      end
    end
  end

  // Capture storage, no reset needed: reads are masked while empty
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cur;
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : head.data;
  assign rd_keep  = empty ? '0 : head.keep;
  assign rd_last  = ~empty & head.last;

endmodule

// File: tb/tb_axis_sink_bfm.sv
// Directed bench for axis_sink_bfm (DATA_BYTES=4, DEPTH=16): ready modes, FIFO
// ordering/back-pressure, counters, clr, stability flag and async reset.
module tb_axis_sink_bfm;

  logic        aclk = 1'b0;
  logic        areset, clr, rd_ready;
  logic [1:0]  mode;
  logic [7:0]  rnd_thr, per_len, per_on;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        rd_valid, rd_last, err_stable;
  logic [31:0] rd_data, beat_cnt, pkt_cnt, byte_cnt;
  logic [3:0]  rd_keep;

  int n_chk  = 0;
  int n_fail = 0;

  axis_sink_bfm #(.DATA_BYTES(4), .DEPTH(16), .LFSR_SEED(16'hACE1)) dut (
    .aclk(aclk), .areset(areset), .clr(clr), .mode(mode), .rnd_thr(rnd_thr),
    .per_len(per_len), .per_on(per_on), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_keep(rd_keep), .rd_last(rd_last),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_stable(err_stable)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  // Offer one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (s_axis_tready) ok = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  // Finish the current stalled offer legally before deasserting tvalid
  task automatic drop_valid();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (s_axis_tready) done = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    if (!done) chk("drop_timeout", 32'(done), 32'd1);
  endtask

  // Random mode from reset; compare TREADY against an LFSR reference every cycle
  task automatic run_rand(output int acc, output int bad);
    logic [15:0] m;
    logic        exp_r;
    areset = 1'b1; mode = 2'd2; rnd_thr = 8'd128; rd_ready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h5555_0000; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
    tick(); tick();
    areset = 1'b0;
    m = 16'hACE1; acc = 0; bad = 0;
    for (int k = 0; k < 4096; k++) begin
      exp_r = (k > 0) ? (m[7:0] < 8'd128) : 1'b0;
      if (s_axis_tready !== exp_r) bad++;
      if (s_axis_tready) acc++;
      tick();
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
  endtask

  initial begin
    int pk_len [3] = '{1, 5, 4};
    int n, acc, rd_idx, last, irregular, acc1, bad1, acc2, bad2;
    logic seen;
    logic [31:0] d;

    areset = 1'b1; clr = 1'b0; mode = 2'd0; rnd_thr = 8'd0; per_len = 8'd0; per_on = 8'd0;
    rd_ready = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    tick(); tick();
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_beat", beat_cnt, 32'd0);
    chk("rst_err", 32'(err_stable), 32'd0);
    areset = 1'b0;
    chk("first_cycle_tready", 32'(s_axis_tready), 32'd0);
    tick();
    chk("second_cycle_tready", 32'(s_axis_tready), 32'd1);

    // T1: three packets 1/5/4, each beat visible on rd_* the cycle after acceptance
    n = 0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < pk_len[p]; b++) begin
        d = 32'hA000_0000 + 32'(n);
        send_beat(d, 4'hF, (b == pk_len[p] - 1));
        chk("t1_rd_valid", 32'(rd_valid), 32'd1);
        chk("t1_rd_data", rd_data, d);
        chk("t1_rd_last", 32'(rd_last), 32'(b == pk_len[p] - 1));
        n++;
      end
    end
    chk("t1_rd_keep", 32'(rd_keep), 32'hF);
    chk("t1_beat", beat_cnt, 32'd10);
    chk("t1_pkt", pkt_cnt, 32'd3);
    chk("t1_byte", byte_cnt, 32'd40);
    tick();
    chk("t1_drained", 32'(rd_valid), 32'd0);

    // T2: FIFO fills at 16 with rd_ready low, then all 20 come out in order
    do_clr();
    rd_ready = 1'b0; acc = 0;
    s_axis_tvalid = 1'b1; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0; s_axis_tdata = 32'hB000_0000;
    for (int c = 0; c < 40; c++) begin
      if (s_axis_tready) acc++;
      tick();
      s_axis_tdata = 32'hB000_0000 + 32'(acc);
    end
    chk("t2_accepted", 32'(acc), 32'd16);
    chk("t2_full_tready", 32'(s_axis_tready), 32'd0);
    chk("t2_beat", beat_cnt, 32'd16);
    chk("t2_head", rd_data, 32'hB000_0000);
    rd_ready = 1'b1; rd_idx = 0;
    for (int c = 0; c < 100 && rd_idx < 20; c++) begin
      if (rd_valid) begin
        chk("t2_order", rd_data, 32'hB000_0000 + 32'(rd_idx));
        rd_idx++;
      end
      if (s_axis_tvalid && s_axis_tready) acc++;
      tick();
      if (acc == 20) s_axis_tvalid = 1'b0;
      else s_axis_tdata = 32'hB000_0000 + 32'(acc);
    end
    chk("t2_read_count", 32'(rd_idx), 32'd20);
    chk("t2_beat_total", beat_cnt, 32'd20);
    chk("t2_err", 32'(err_stable), 32'd0);

    // T3: stall mode never accepts; then dropping tvalid mid-stall is flagged
    mode = 2'd1;
    do_clr();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hC0DE_0003; seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      seen |= s_axis_tready;
      tick();
    end
    chk("t3_tready_seen", 32'(seen), 32'd0);
    chk("t3_beat", beat_cnt, 32'd0);
    chk("t3_byte", byte_cnt, 32'd0);
    chk("t3_err", 32'(err_stable), 32'd0);
    s_axis_tvalid = 1'b0;
    tick();
    chk("t6_drop_err", 32'(err_stable), 32'd1);
    tick(); tick();
    chk("t6_err_sticky", 32'(err_stable), 32'd1);

    // T4: periodic 1-of-4 ready over 1000 cycles
    mode = 2'd3; per_len = 8'd4; per_on = 8'd1;
    do_clr();
    chk("t4_err_cleared", 32'(err_stable), 32'd0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h4444_4444;
    acc = 0; last = -1; irregular = 0;
    for (int c = 0; c < 1000; c++) begin
      if (s_axis_tready) begin
        acc++;
        if (last >= 0 && c - last != 4) irregular++;
        last = c;
      end
      tick();
    end
    chk("t4_ready_cycles", 32'(acc), 32'd250);
    chk("t4_irregular", 32'(irregular), 32'd0);
    chk("t4_beat", beat_cnt, 32'd250);
    drop_valid();

    // T5: random ready, twice from reset, identical and matching the LFSR reference
    run_rand(acc1, bad1);
    chk("t5_ref_mismatch", 32'(bad1), 32'd0);
    chk("t5_beat", beat_cnt, 32'(acc1));
    chk("t5_range", 32'(acc1 >= 1898 && acc1 <= 2198), 32'd1);
    run_rand(acc2, bad2);
    chk("t5_replay_mismatch", 32'(bad2), 32'd0);
    chk("t5_replay_count", 32'(acc2), 32'(acc1));
    drop_valid();

    // T6: data change while stalled, then clr with switch to free mode
    mode = 2'd1;
    do_clr();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hD000_0000; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
    tick(); tick();
    chk("t6_err_before", 32'(err_stable), 32'd0);
    s_axis_tdata = 32'hD000_0001;
    tick();
    chk("t6_change_err", 32'(err_stable), 32'd1);
    clr = 1'b1; mode = 2'd0;
    chk("t6_clr_cycle_tready", 32'(s_axis_tready), 32'd0);
    tick();
    clr = 1'b0;
    chk("t6_clr_err", 32'(err_stable), 32'd0);
    chk("t6_clr_beat", beat_cnt, 32'd0);
    chk("t6_post_clr_tready", 32'(s_axis_tready), 32'd0);
    tick();
    chk("t6_tready_back", 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
    chk("t6_beat_after", beat_cnt, 32'd1);
    chk("t6_byte_after", byte_cnt, 32'd4);
    chk("t6_rd_data", rd_data, 32'hD000_0001);
    send_beat(32'hE000_0000, 4'b0110, 1'b1);
    chk("t6_partial_byte", byte_cnt, 32'd6);
    chk("t6_partial_pkt", pkt_cnt, 32'd1);
    chk("t6_rd_keep", 32'(rd_keep), 32'h6);
    chk("t6_rd_last", 32'(rd_last), 32'd1);

    // Async reset mid-packet discards everything at once
    rd_ready = 1'b0;
    send_beat(32'hF000_0001, 4'hF, 1'b0);
    chk("ar_pre_valid", 32'(rd_valid), 32'd1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hF000_0002;
    areset = 1'b1;
    #2;
    chk("ar_tready", 32'(s_axis_tready), 32'd0);
    chk("ar_rd_valid", 32'(rd_valid), 32'd0);
    chk("ar_rd_data", rd_data, 32'd0);
    chk("ar_beat", beat_cnt, 32'd0);
    chk("ar_pkt", pkt_cnt, 32'd0);
    chk("ar_byte", byte_cnt, 32'd0);
    chk("ar_err", 32'(err_stable), 32'd0);
    s_axis_tvalid = 1'b0;
    tick();
    areset = 1'b0;
    chk("ar_first_tready", 32'(s_axis_tready), 32'd0);
    tick();
    chk("ar_second_tready", 32'(s_axis_tready), 32'd1);
    chk("ar_fifo_empty", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
